// File: rtl/vadd_a_b_example_axi_write_master_pkg.sv
// rtl/vadd_a_b_example_axi_write_master_pkg.sv - shared AXI constants, FSM encoding and log2 helper
// Purpose : common definitions for the AXI write master and its counters.
// Ports   : none (package).
package vadd_a_b_example_axi_write_master_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE = 2'd0;
  localparam fsm_state_t ST_RUN  = 2'd1;
  localparam fsm_state_t ST_DONE = 2'd2;

  // Ceiling log2; used for awsize and counter widths.
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vadd_a_b_example_axi_write_master_if.sv
// rtl/vadd_a_b_example_axi_write_master_if.sv - AXIS input and AXI4 write-channel bundle
// Purpose : groups the stream handshake and the AW/W/B channels of the write master.
// Ports   : s_axis_* (stream in), m_axi_aw* (address), m_axi_w* (data), m_axi_b* (response).
//           master modport = write-master view, slave modport = adder/memory view.
interface vadd_a_b_example_axi_write_master_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512
);
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic [DATA_WIDTH-1:0]   s_axis_tdata;

  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic [1:0]              m_axi_awburst;
  logic [2:0]              m_axi_awsize;

  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;

  logic                    m_axi_bvalid;
  logic                    m_axi_bready;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, m_axi_awready, m_axi_wready, m_axi_bvalid,
    output s_axis_tready, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awburst,
           m_axi_awsize, m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_bready
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, m_axi_awready, m_axi_wready, m_axi_bvalid,
    input  s_axis_tready, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awburst,
           m_axi_awsize, m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_bready
  );

endinterface

// File: rtl/vadd_a_b_example_axi_write_master_counter.sv
// rtl/vadd_a_b_example_axi_write_master_counter.sv - loadable up/down counter
// Purpose : generic counter used for burst, beat, response and outstanding tracking.
// Ports   : clk, rst_n (async active-low), i_load/i_load_value (priority load),
//           i_incr/i_decr (cancel when both set), o_count, o_is_zero.
module vadd_a_b_example_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_incr,
  input  logic             i_decr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_is_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_incr && !i_decr) begin
      r_count <= r_count + WIDTH'(1);
    end else if (i_decr && !i_incr) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count   = r_count;
  assign o_is_zero = (r_count == '0);

endmodule

// File: rtl/vadd_a_b_example_axi_write_master.sv
// rtl/vadd_a_b_example_axi_write_master.sv - stream-to-memory AXI4 INCR burst writer
// Purpose : takes the adder's output stream and writes it as AXI4 INCR bursts starting at
//           ctrl_addr_offset; pulses ctrl_done after the final write response.
// Ports   : aclk, aresetn (async active-low), ctrl_start/ctrl_done (kernel control),
//           ctrl_addr_offset, ctrl_xfer_size_in_bytes (latched at start),
//           bus (master modport: s_axis_* in, m_axi_aw*/w*/b* out).
module vadd_a_b_example_axi_write_master
  import vadd_a_b_example_axi_write_master_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_BURST_LEN        = 64,
  parameter int C_MAX_OUTSTANDING  = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          ctrl_start,
  output logic                          ctrl_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
  vadd_a_b_example_axi_write_master_if.master bus
);

  localparam int BPB      = C_M_AXI_DATA_WIDTH / 8;
  localparam int BPB_LOG2 = log2_ceil(BPB);
  // One extra bit so the rounded-up beat count of a maximal size cannot overflow.
  localparam int CW       = C_XFER_SIZE_WIDTH + 1;
  localparam int OW       = log2_ceil(C_MAX_OUTSTANDING) + 1;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES = C_M_AXI_ADDR_WIDTH'(C_BURST_LEN * BPB);
  localparam logic [7:0] FULL_LEN_M1 = 8'(C_BURST_LEN - 1);

  fsm_state_t                    r_state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [CW-1:0]                 r_bursts;
  logic [7:0]                    r_last_len_m1;

  logic          w_start, w_run;
  logic          w_aw_hs, w_w_hs, w_wlast_hs, w_b_hs;
  logic [CW-1:0] w_beats, w_rem, w_nbursts;
  logic [7:0]    w_last_len_m1;
  logic [CW-1:0] w_aw_cnt, w_w_cnt, w_b_cnt;
  logic [OW-1:0] w_out_cnt;
  logic [7:0]    w_beat_cnt;
  logic          w_aw_zero, w_w_zero, w_b_zero, w_out_zero, w_beat_zero;
  logic          w_unused_zero;
  logic          w_w_active, w_aw_final, w_w_final, w_all_done;

  assign w_start = (r_state == ST_IDLE) && ctrl_start;
  assign w_run   = (r_state == ST_RUN);

  // Transfer plan computed from the size presented with the start pulse.
  assign w_beats       = (CW'(ctrl_xfer_size_in_bytes) + CW'(BPB - 1)) >> BPB_LOG2;
  assign w_rem         = w_beats % CW'(C_BURST_LEN);
  assign w_nbursts     = (w_beats / CW'(C_BURST_LEN)) + CW'(w_rem != '0);
  assign w_last_len_m1 = (w_rem == '0) ? FULL_LEN_M1 : 8'(w_rem - CW'(1));

  assign w_aw_hs    = bus.m_axi_awvalid && bus.m_axi_awready;
  assign w_w_hs     = bus.m_axi_wvalid && bus.m_axi_wready;
  assign w_wlast_hs = w_w_hs && bus.m_axi_wlast;
  assign w_b_hs     = bus.m_axi_bvalid && bus.m_axi_bready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= ST_IDLE;
      r_bursts      <= '0;
      r_last_len_m1 <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ctrl_start) begin
            r_state       <= ST_RUN;
            r_bursts      <= w_nbursts;
            r_last_len_m1 <= w_last_len_m1;
          end
        end
        ST_RUN:  if (w_all_done) r_state <= ST_DONE;
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Running burst address: only advances on acceptance, so it holds while awvalid waits.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awaddr <= '0;
    end else if (w_start) begin
      r_awaddr <= ctrl_addr_offset;
    end else if (w_aw_hs) begin
      r_awaddr <= r_awaddr + BURST_BYTES;
    end
  end

  vadd_a_b_example_counter #(.WIDTH(CW)) u_aw_cnt (
    .clk(aclk), .rst_n(aresetn), .i_load(w_start), .i_load_value('0),
    .i_incr(w_aw_hs), .i_decr(1'b0), .o_count(w_aw_cnt), .o_is_zero(w_aw_zero)
  );

  vadd_a_b_example_counter #(.WIDTH(CW)) u_w_cnt (
    .clk(aclk), .rst_n(aresetn), .i_load(w_start), .i_load_value('0),
    .i_incr(w_wlast_hs), .i_decr(1'b0), .o_count(w_w_cnt), .o_is_zero(w_w_zero)
  );

  vadd_a_b_example_counter #(.WIDTH(CW)) u_b_cnt (
    .clk(aclk), .rst_n(aresetn), .i_load(w_start), .i_load_value('0),
    .i_incr(w_b_hs), .i_decr(1'b0), .o_count(w_b_cnt), .o_is_zero(w_b_zero)
  );

  vadd_a_b_example_counter #(.WIDTH(OW)) u_out_cnt (
    .clk(aclk), .rst_n(aresetn), .i_load(w_start), .i_load_value('0),
    .i_incr(w_aw_hs), .i_decr(w_b_hs), .o_count(w_out_cnt), .o_is_zero(w_out_zero)
  );

  // Beat index within the current W burst; the load on wlast wins over the increment.
  vadd_a_b_example_counter #(.WIDTH(8)) u_beat_cnt (
    .clk(aclk), .rst_n(aresetn), .i_load(w_start || w_wlast_hs), .i_load_value('0),
    .i_incr(w_w_hs), .i_decr(1'b0), .o_count(w_beat_cnt), .o_is_zero(w_beat_zero)
  );

  assign w_unused_zero = ^{w_aw_zero, w_w_zero, w_b_zero, w_beat_zero};

  assign w_aw_final = (w_aw_cnt == r_bursts - CW'(1));
  assign w_w_final  = (w_w_cnt == r_bursts - CW'(1));
  // A W burst may only start once its own AW has been accepted.
  assign w_w_active = w_run && (w_w_cnt < w_aw_cnt);
  assign w_all_done = (w_aw_cnt == r_bursts) && (w_b_cnt == r_bursts) && w_out_zero;

  assign bus.m_axi_awvalid = w_run && (w_aw_cnt < r_bursts) &&
                             (w_out_cnt < OW'(C_MAX_OUTSTANDING));
  assign bus.m_axi_awaddr  = r_awaddr;
  assign bus.m_axi_awlen   = w_aw_final ? r_last_len_m1 : FULL_LEN_M1;
  assign bus.m_axi_awburst = AXI_BURST_INCR;
  assign bus.m_axi_awsize  = 3'(BPB_LOG2);

  // Zero-latency pass-through: a stream beat moves only in the cycle the W beat is accepted.
  assign bus.m_axi_wvalid  = bus.s_axis_tvalid && w_w_active;
  assign bus.s_axis_tready = bus.m_axi_wready && w_w_active;
  assign bus.m_axi_wdata   = bus.s_axis_tdata;
  assign bus.m_axi_wstrb   = '1;
  assign bus.m_axi_wlast   = (w_beat_cnt == (w_w_final ? r_last_len_m1 : FULL_LEN_M1));

  assign bus.m_axi_bready  = w_run;
  assign ctrl_done         = (r_state == ST_DONE);

endmodule
